// File: rtl/booth_div.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, followed by a sign-fix cycle.
module booth_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t           r_state, w_next;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_qm;
   logic [WIDTH:0]   r_dvs;
   logic [CW-1:0]    r_cnt;
   logic             r_sign_q, r_sign_r, r_dbz_p, r_ovf_p;

   logic             w_accept;
   logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
   logic             w_dbz_det, w_ovf_det;
   logic [WIDTH+1:0] w_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_qbit;

   assign w_accept = start && (r_state == S_IDLE);
   assign busy     = (r_state != S_IDLE);

   // W-bit unsigned magnitude is exact even for the most-negative operand
   assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
   assign w_dbz_det = (divisor == '0);
   assign w_ovf_det = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

   assign w_sh   = {r_rem, r_qm[WIDTH-1]};
   assign w_qbit = (w_sh >= {1'b0, r_dvs});
   assign w_diff = w_sh[WIDTH:0] - r_dvs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start)              w_next = S_CALC;
         S_CALC:  if (r_cnt == CW'(1))    w_next = S_FIX;
         S_FIX:                           w_next = S_IDLE;
         default:                         w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem     <= '0;
         r_qm      <= '0;
         r_dvs     <= '0;
         r_cnt     <= '0;
         r_sign_q  <= 1'b0;
         r_sign_r  <= 1'b0;
         r_dbz_p   <= 1'b0;
         r_ovf_p   <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rem    <= '0;
                  r_qm     <= w_dvd_mag;
                  r_dvs    <= {1'b0, w_dvs_mag};
                  r_cnt    <= CW'(WIDTH);
                  r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_sign_r <= dividend[WIDTH-1];
                  r_dbz_p  <= w_dbz_det;
                  r_ovf_p  <= w_ovf_det;
               end
            end
            S_CALC: begin
               // the dividend register doubles as the quotient shift register
               r_rem <= w_qbit ? w_diff : w_sh[WIDTH:0];
               r_qm  <= {r_qm[WIDTH-2:0], w_qbit};
               r_cnt <= r_cnt - CW'(1);
            end
            S_FIX: begin
               // a zero divisor leaves |dividend| in r_rem, so remainder == dividend
               quotient  <= r_dbz_p ? '1 : (r_sign_q ? -r_qm : r_qm);
               remainder <= r_ovf_p ? '0 :
                            (r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);
               dbz       <= r_dbz_p;
               ovf       <= r_ovf_p;
               done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_div.sv
// Scoreboard bench for booth_div at WIDTH=8 and WIDTH=16: directed corner cases,
// handshake and abort behaviour, then random operand pairs.
module tb_booth_div;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st8 = 1'b0, st16 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy8, done8, dbz8, ovf8;
   logic [7:0]  q8, r8;
   logic        busy16, done16, dbz16, ovf16;
   logic [15:0] q16, r16;

   exp_t sb8[$];
   exp_t sb16[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   booth_div #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(st8), .dividend(a8), .divisor(b8),
      .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
      .dbz(dbz8), .ovf(ovf8)
   );

   booth_div #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(st16), .dividend(a16), .divisor(b16),
      .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
      .dbz(dbz16), .ovf(ovf16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic exp_t ref_div(input int w, input longint a, input longint b);
      exp_t   e;
      longint mask;
      longint mn;
      mask  = (longint'(1) << w) - 1;
      mn    = -(longint'(1) << (w - 1));
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (b == 0) begin
         e.q   = 32'(mask);
         e.r   = 32'(a & mask);
         e.dbz = 1'b1;
      end else if (a == mn && b == -1) begin
         e.q   = 32'(mn & mask);
         e.r   = 32'd0;
         e.ovf = 1'b1;
      end else begin
         e.q = 32'((a / b) & mask);
         e.r = 32'((a % b) & mask);
      end
      return e;
   endfunction

   task automatic sample(input int w, output logic [31:0] q, output logic [31:0] r,
                         output logic bz, output logic ov, output logic bsy, output logic dn);
      if (w == 8) begin
         q = {24'd0, q8};  r = {24'd0, r8};
         bz = dbz8; ov = ovf8; bsy = busy8; dn = done8;
      end else begin
         q = {16'd0, q16}; r = {16'd0, r16};
         bz = dbz16; ov = ovf16; bsy = busy16; dn = done16;
      end
   endtask

   task automatic issue(input int w, input longint a, input longint b, input bit push);
      if (push) begin
         if (w == 8) sb8.push_back(ref_div(w, a, b));
         else        sb16.push_back(ref_div(w, a, b));
      end
      if (w == 8) begin a8 = a[7:0];   b8 = b[7:0];   st8 = 1'b1;  end
      else        begin a16 = a[15:0]; b16 = b[15:0]; st16 = 1'b1; end
      tick();
      st8  = 1'b0;
      st16 = 1'b0;
   endtask

   task automatic wait_done(input int w, output int n);
      logic [31:0] q, r;
      logic        bz, ov, bsy, dn;
      exp_t        e;
      int          sz;
      n = 0;
      sample(w, q, r, bz, ov, bsy, dn);
      while (!dn && n < 64) begin
         tick();
         n++;
         sample(w, q, r, bz, ov, bsy, dn);
      end
      if (!dn) begin
         chk("done_timeout", {31'd0, dn}, 32'd1);
      end else begin
         sz = (w == 8) ? sb8.size() : sb16.size();
         if (sz == 0) begin
            chk("sb_underflow", 32'(sz), 32'd1);
         end else begin
            e = (w == 8) ? sb8.pop_front() : sb16.pop_front();
            chk("quotient", q, e.q);
            chk("remainder", r, e.r);
            chk("dbz", {31'd0, bz}, {31'd0, e.dbz});
            chk("ovf", {31'd0, ov}, {31'd0, e.ovf});
            chk("busy_at_done", {31'd0, bsy}, 32'd0);
         end
      end
   endtask

   task automatic op(input int w, input longint a, input longint b);
      int n;
      issue(w, a, b, 1'b1);
      chk("busy_after_accept", {31'd0, (w == 8) ? busy8 : busy16}, 32'd1);
      wait_done(w, n);
      chk("latency", 32'(n), 32'(w + 1));
   endtask

   initial begin
      int          n;
      int          seen;
      longint      a, b;
      logic [31:0] q, r;
      logic        bz, ov, bsy, dn;

      // reset state, held three cycles
      tick(); tick(); tick();
      sample(8, q, r, bz, ov, bsy, dn);
      chk("rst_q", q, 32'd0);
      chk("rst_r", r, 32'd0);
      chk("rst_busy", {31'd0, bsy}, 32'd0);
      chk("rst_done", {31'd0, dn}, 32'd0);
      chk("rst_flags", {30'd0, bz, ov}, 32'd0);
      sample(16, q, r, bz, ov, bsy, dn);
      chk("rst16_q", q, 32'd0);
      rst = 1'b0;
      tick();

      // signs and corners
      op(8, 100, 7);
      op(8, -100, 7);
      op(8, 100, -7);
      op(8, -100, -7);
      op(8, 0, 5);
      op(8, -128, 1);
      op(8, -128, -1);
      op(8, 5, 0);
      op(8, 9, 3);

      // start while busy is ignored; a back-to-back start keeps prior outputs
      issue(8, 100, 7, 1'b1);
      tick(); tick(); tick();
      a8 = 8'd50; b8 = 8'd5; st8 = 1'b1;
      tick();
      st8 = 1'b0;
      wait_done(8, n);
      chk("hs_latency", 32'(n), 32'd5);
      issue(8, 77, 5, 1'b1);
      sample(8, q, r, bz, ov, bsy, dn);
      chk("hold_q", q, 32'd14);
      chk("hold_r", r, 32'd2);
      chk("hold_done", {31'd0, dn}, 32'd0);
      wait_done(8, n);
      chk("b2b_latency", 32'(n), 32'd9);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) seen++;
      end
      chk("extra_done", 32'(seen), 32'd0);

      // abort mid-calculation
      issue(8, 100, 7, 1'b0);
      tick(); tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      sample(8, q, r, bz, ov, bsy, dn);
      chk("abort_q", q, 32'd0);
      chk("abort_r", r, 32'd0);
      chk("abort_busy", {31'd0, bsy}, 32'd0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done8) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      op(8, 127, -128);

      // random pairs, with periodic divide-by-zero and overflow operands
      for (int i = 0; i < 1000; i++) begin
         a = longint'($urandom_range(0, 255)) - 128;
         b = longint'($urandom_range(0, 255)) - 128;
         if (i % 50 == 7)  b = 0;
         if (i % 97 == 11) begin a = -128; b = -1; end
         op(8, a, b);
      end
      op(16, -32768, -1);
      op(16, 1234, 0);
      for (int i = 0; i < 1000; i++) begin
         a = longint'($urandom_range(0, 65535)) - 32768;
         b = longint'($urandom_range(0, 65535)) - 32768;
         if (i % 8 == 3)   b = longint'($urandom_range(0, 30)) - 15;
         if (i % 61 == 5)  b = 0;
         if (i % 89 == 13) begin a = -32768; b = -1; end
         op(16, a, b);
      end

      chk("sb8_left", 32'(sb8.size()), 32'd0);
      chk("sb16_left", 32'(sb16.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
